fsm_step_controller: RTL
========================

Name: fsm_step_controller

Overview:
Debug-side driver for the FSM core's step interface. It generates single-cycle clk_enable pulses in single-step or free-run mode and presents a latched input vector to the core. For every step it records the pre-step transition {x, state, z} into a trace FIFO, which the debug display/UART logic reads out. It sits between the board controls (buttons/switches) and the FSM core.

Parameters:
TRACE_DEPTH, 16, trace FIFO entries; power of two, minimum 2.
RUN_DIV, 4, idle cycles between steps in run mode; minimum 1.
X_W, 2, FSM input width.
S_W, 4, FSM state width.
Z_W, 4, FSM output width.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cmd_step  in  1  single-cycle pulse; request one step.
cmd_run  in  1  single-cycle pulse; enter free-run.
cmd_halt  in  1  single-cycle pulse; leave free-run.
x_sel  in  X_W  user input switches; must be synchronous to clk.
state_in  in  S_W  core present state (debug port).
z_in  in  Z_W  core output.
step_en  out  1  drives the core clock enable; registered.
x_out  out  X_W  drives the core input; registered.
running  out  1  high while in run mode.
step_count  out  16  steps issued; wraps 0xFFFF->0.
trace_rd  in  1  pop request.
trace_clr  in  1  flush the trace.
trace_data  out  X_W+S_W+Z_W  head entry {x, state, z}; first-word-fall-through.
trace_empty  out  1  FIFO empty.
trace_count  out  clog2(TRACE_DEPTH)+1  current occupancy.
trace_overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous: FSM to IDLE; step_en=0, x_out=0, running=0, step_count=0, FIFO emptied, trace_overflow=0. A reset during PULSE drops step_en immediately, and no trace write occurs.
- States: IDLE, SETUP, PULSE, RUN_WAIT.
- IDLE command priority: cmd_halt > cmd_step > cmd_run.
  - cmd_step -> SETUP.
  - cmd_run -> RUN_WAIT with running=1 and the counter loaded to RUN_DIV-1.
- SETUP: x_out <= x_sel; next PULSE.
- PULSE: step_en=1 for exactly this cycle. In the same cycle:
  - Trace write of {x_out, state_in, z_in}. This is the core's value before the edge, i.e. the transition taken.
  - step_count increments.
  - Next state: RUN_WAIT (counter reloaded) if running, else IDLE.
- RUN_WAIT: the counter decrements each cycle; at 0 go to SETUP.
  - Run-mode step period is RUN_DIV+2 cycles.
  - x_sel is resampled for every step.
- cmd_halt:
  - In RUN_WAIT: clears running, goes to IDLE next cycle.
  - In SETUP/PULSE: clears running; the pending pulse completes, then IDLE. A pulse is never truncated or skipped once SETUP is entered.
- cmd_step outside IDLE is ignored. cmd_run outside IDLE is ignored.
- Single-step latency: cmd_step sampled at edge N; step_en high in cycle N+2.
- Trace FIFO:
  - Write when full: entry dropped, trace_overflow set.
  - trace_rd when empty is ignored.
  - Read and write in the same cycle on a full FIFO: both are accepted and the count is unchanged.
  - Read and write in the same cycle on an empty FIFO: the write is accepted, the read is ignored.
  - trace_clr: pointers, count and overflow are zeroed; a coincident write or read is discarded.
  - Pointers wrap modulo TRACE_DEPTH.

Decomposition:
- Package fsm_dbg_pkg: controller state encoding; X_W/S_W/Z_W defaults; trace entry width and field offsets (z at LSBs, then state, then x).
- Sub-module fsm_trace_fifo: a synchronous FWFT FIFO with count and sticky overflow, parameterised by depth and width.

Test Plan:
1. Reset, then x_sel=2'b10, state_in=0, z_in=0, cmd_step at edge 5 -> step_en high only in cycle 7; x_out=2'b10 from cycle 6; trace entry {10,0000,0000}; step_count=1.
2. RUN_DIV=4, cmd_run, 5 steps observed -> step_en pulses spaced exactly 6 cycles apart; running=1; step_count=5; trace_count=5.
3. cmd_halt issued during SETUP -> that pulse still occurs; running drops; returns to IDLE; no further pulses for 20 cycles.
4. Issue 17 steps with TRACE_DEPTH=16 and no reads -> trace_count=16, trace_overflow=1; first entry preserved at the head; trace_clr -> count=0, overflow=0, trace_empty=1.
5. Full FIFO, with trace_rd coinciding with PULSE -> count stays 16, overflow stays 0, head advances to the second entry.
6. Assert reset during PULSE -> step_en=0 immediately, no trace entry written, step_count=0; a cmd_step and cmd_run in the same cycle from IDLE -> single step only, running=0.

Source files
------------

// File: rtl/fsm_dbg_pkg.sv
// rtl/fsm_dbg_pkg.sv - shared types and sizing for the FSM step controller
// Purpose: controller state encoding, default widths and trace entry layout.
// Trace entry layout: z at the LSBs, then state, then x at the MSBs.
package fsm_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_RUN_WAIT
  } ctrl_state_t;

  localparam int DEF_X_W         = 2;
  localparam int DEF_S_W         = 4;
  localparam int DEF_Z_W         = 4;
  localparam int DEF_TRACE_DEPTH = 16;
  localparam int DEF_RUN_DIV     = 4;

  function automatic int entry_w(input int x_w, input int s_w, input int z_w);
    return x_w + s_w + z_w;
  endfunction

  function automatic int s_lsb(input int z_w);
    return z_w;
  endfunction

  function automatic int x_lsb(input int s_w, input int z_w);
    return z_w + s_w;
  endfunction

endpackage

// File: rtl/fsm_step_controller_if.sv
// rtl/fsm_step_controller_if.sv - trace read-out port of the step controller
// Purpose: groups the trace FIFO read side used by the display/UART logic.
// Ports: trace_rd, trace_clr (reader -> controller);
//        trace_data, trace_empty, trace_count, trace_overflow (controller -> reader).
// Modports: master = reader side, slave = controller side.
interface fsm_step_controller_if
  import fsm_dbg_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int S_W         = DEF_S_W,
  parameter int Z_W         = DEF_Z_W,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
);
  localparam int ENTRY_W = entry_w(X_W, S_W, Z_W);
  localparam int CNT_W   = $clog2(TRACE_DEPTH) + 1;

  logic               trace_rd;
  logic               trace_clr;
  logic [ENTRY_W-1:0] trace_data;
  logic               trace_empty;
  logic [CNT_W-1:0]   trace_count;
  logic               trace_overflow;

  modport master (
    output trace_rd, trace_clr,
    input  trace_data, trace_empty, trace_count, trace_overflow
  );

  modport slave (
    input  trace_rd, trace_clr,
    output trace_data, trace_empty, trace_count, trace_overflow
  );
endinterface

// File: rtl/fsm_trace_fifo.sv
// rtl/fsm_trace_fifo.sv - first-word-fall-through FIFO with count and sticky overflow
// Purpose: holds one entry per issued step until the debug reader pops it.
// Ports: clk, reset (async, active-high); wr/wr_data push; rd pop; clr flush;
//        rd_data head entry; empty; count occupancy; overflow sticky drop flag.
module fsm_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd,
  input  logic                       clr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             rd_ok;
  logic             wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_ok   = rd && !empty;
  // A full FIFO still takes a write when a read frees the head slot this cycle.
  assign wr_ok   = wr && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
      if (wr && !wr_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fsm_step_controller.sv
// rtl/fsm_step_controller.sv - single-step / free-run clock-enable driver for the FSM core
// Purpose: issues one-cycle step_en pulses, presents a latched input vector and
//          records each transition {x, state, z} into a trace FIFO.
// Ports: clk, reset (async, active-high); cmd_step/cmd_run/cmd_halt command pulses;
//        x_sel switches; state_in/z_in core debug values; step_en, x_out to the core;
//        running, step_count status; trace (slave) FIFO read-out port.
module fsm_step_controller
  import fsm_dbg_pkg::*;
#(
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
  parameter int RUN_DIV     = DEF_RUN_DIV,
  parameter int X_W         = DEF_X_W,
  parameter int S_W         = DEF_S_W,
  parameter int Z_W         = DEF_Z_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_step,
  input  logic           cmd_run,
  input  logic           cmd_halt,
  input  logic [X_W-1:0] x_sel,
  input  logic [S_W-1:0] state_in,
  input  logic [Z_W-1:0] z_in,
  output logic           step_en,
  output logic [X_W-1:0] x_out,
  output logic           running,
  output logic [15:0]    step_count,
  fsm_step_controller_if.slave trace
);
  localparam int ENTRY_W = entry_w(X_W, S_W, Z_W);
  localparam int XL      = x_lsb(S_W, Z_W);
  localparam int SL      = s_lsb(Z_W);
  localparam int DIV_W   = $clog2(RUN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RUN_DIV - 1);

  ctrl_state_t        state, state_d;
  logic               running_d;
  logic [DIV_W-1:0]   div_cnt, div_d;
  logic [X_W-1:0]     x_d;
  logic               trace_wr;
  logic [ENTRY_W-1:0] wr_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      div_cnt    <= '0;
      x_out      <= '0;
      step_en    <= 1'b0;
      step_count <= '0;
    end else begin
      state   <= state_d;
      running <= running_d;
      div_cnt <= div_d;
      x_out   <= x_d;
      // Registered copy of "next state is PULSE": high exactly while in PULSE.
      step_en <= (state_d == ST_PULSE);
      if (state == ST_PULSE) step_count <= step_count + 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    running_d = running;
    div_d     = div_cnt;
    x_d       = x_out;
    trace_wr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cmd_halt && cmd_step) begin
          state_d = ST_SETUP;
          x_d     = x_sel;
        end else if (!cmd_halt && cmd_run) begin
          state_d   = ST_RUN_WAIT;
          running_d = 1'b1;
          div_d     = DIV_LOAD;
        end
      end
      ST_SETUP: begin
        // Once committed to a step the pulse always follows; halt only ends run mode.
        state_d = ST_PULSE;
        if (cmd_halt) running_d = 1'b0;
      end
      ST_PULSE: begin
        trace_wr = 1'b1;
        if (cmd_halt) running_d = 1'b0;
        if (running && !cmd_halt) begin
          state_d = ST_RUN_WAIT;
          div_d   = DIV_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN_WAIT: begin
        if (cmd_halt) begin
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (div_cnt == '0) begin
          state_d = ST_SETUP;
          x_d     = x_sel;
        end else begin
          div_d = div_cnt - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Values sampled while step_en is high are the core's pre-edge transition.
  always_comb begin
    wr_entry            = '0;
    wr_entry[XL +: X_W] = x_out;
    wr_entry[SL +: S_W] = state_in;
    wr_entry[0 +: Z_W]  = z_in;
  end

  fsm_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (trace_wr),
    .wr_data  (wr_entry),
    .rd       (trace.trace_rd),
    .clr      (trace.trace_clr),
    .rd_data  (trace.trace_data),
    .empty    (trace.trace_empty),
    .count    (trace.trace_count),
    .overflow (trace.trace_overflow)
  );

endmodule
